// File: rtl/fetch_align_if.sv
// Fetch front-end bundle: downstream handshake, redirect/BTB inputs, SRAM port and decoded outputs.
// master = fetch_align itself; slave = the surrounding pipeline/SRAM/testbench.
interface fetch_align_if;
    logic        fet_stall;
    logic        fet_flush;
    logic [31:0] fet_redirect_pc;
    logic [31:0] btb_pc;
    logic [31:0] btb_instr;
    logic        btb_valid;
    logic        isram_cs;
    logic [31:0] isram_addr;
    logic [31:0] isram_rdata;
    logic        fet_valid;
    logic [31:0] fetch_pc;
    logic [31:0] rv32_instr_todec;
    logic [15:0] rv16_instr_todec;
    logic        fe2de_rv16;
    logic        predict_bxxtaken;
    logic        cross_bd_ff;
    logic        fet_is_x1;
    logic        fet_is_xn;

    modport master (
        input  fet_stall, fet_flush, fet_redirect_pc, btb_pc, btb_instr, btb_valid, isram_rdata,
        output isram_cs, isram_addr, fet_valid, fetch_pc, rv32_instr_todec, rv16_instr_todec,
               fe2de_rv16, predict_bxxtaken, cross_bd_ff, fet_is_x1, fet_is_xn
    );

    modport slave (
        output fet_stall, fet_flush, fet_redirect_pc, btb_pc, btb_instr, btb_valid, isram_rdata,
        input  isram_cs, isram_addr, fet_valid, fetch_pc, rv32_instr_todec, rv16_instr_todec,
               fe2de_rv16, predict_bxxtaken, cross_bd_ff, fet_is_x1, fet_is_xn
    );
endinterface

// File: rtl/fetch_align.sv
// Fetch aligner: two-word SRAM window, halfword-granular RV32/RVC extraction, BTB redirect bypass, backward-taken prediction.
// Outputs decode from registers (SRAM data +1 cycle); fet_stall freezes the presented instruction while prefetch fills the window.
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    cpurst_n,
    fetch_align_if.master fa
);

    logic [31:0] pc_q, w0_q, w1_q, btb_ins_q;
    logic        w0_v_q, w1_v_q, rd_pend_q, btb_sel_q, drop_q;
    logic [29:0] fptr_q;

    logic [31:0] n_pc, n_w0, n_w1, n_btb_ins;
    logic        n_w0_v, n_w1_v, n_btb_sel, n_drop;
    logic [29:0] n_fptr;

    logic [31:0] instr;
    logic        is16, avail, valid, accept, take, word_chg, rel, issue;
    logic [31:0] br_off, seq_pc, adv_pc;
    logic [29:0] rd_word;
    logic [1:0]  occ;
    logic        jalr, cjr;
    logic [4:0]  jr_rs1;

    always_comb begin
        instr = w0_q;
        if (btb_sel_q) begin
            instr = btb_ins_q;
        end else if (pc_q[1]) begin
            instr = {w1_q[15:0], w0_q[31:16]};
        end
    end

    assign is16   = (instr[1:0] != 2'b11);
    // A 32-bit instruction starting in the upper half also needs the following word.
    assign avail  = btb_sel_q | (w0_v_q & (is16 | ~pc_q[1] | w1_v_q));
    assign valid  = avail & ~fa.fet_flush;
    assign accept = valid & ~fa.fet_stall;
    assign take   = valid & ~is16 & (instr[6:0] == 7'b1100011) & instr[31];

    assign br_off   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign seq_pc   = pc_q + (is16 ? 32'd2 : 32'd4);
    assign adv_pc   = take ? (pc_q + br_off) : seq_pc;
    assign word_chg = (adv_pc[31:2] != pc_q[31:2]);
    assign rel      = accept & word_chg & ~take;

    // Occupancy counts the slot this cycle's accept releases as already free, so a
    // sequential stream never bubbles while the window stays bounded at two words.
    assign occ   = {1'b0, w0_v_q} + {1'b0, w1_v_q} + {1'b0, rd_pend_q};
    assign issue = cpurst_n & (fa.fet_flush | (accept & take) | (rel ? (occ < 2'd3) : (occ < 2'd2)));

    always_comb begin
        rd_word = fptr_q;
        if (fa.fet_flush) begin
            rd_word = fa.fet_redirect_pc[31:2];
        end else if (accept & take) begin
            rd_word = adv_pc[31:2];
        end
    end

    always_comb begin
        n_pc      = pc_q;
        n_w0      = w0_q;
        n_w1      = w1_q;
        n_w0_v    = w0_v_q;
        n_w1_v    = w1_v_q;
        n_btb_sel = btb_sel_q;
        n_btb_ins = btb_ins_q;
        n_drop    = drop_q;
        n_fptr    = fptr_q;

        if (issue) begin
            n_fptr = rd_word + 30'd1;
        end

        if (rd_pend_q) begin
            if (drop_q) begin
                n_drop = 1'b0;
            end else if (!w0_v_q) begin
                n_w0   = fa.isram_rdata;
                n_w0_v = 1'b1;
            end else begin
                n_w1   = fa.isram_rdata;
                n_w1_v = 1'b1;
            end
        end

        // The read returning in a flush cycle is the only one in flight with a
        // one-cycle SRAM, so clearing the window discards it without needing drop.
        if (fa.fet_flush) begin
            n_pc      = {fa.fet_redirect_pc[31:1], 1'b0};
            n_w0_v    = 1'b0;
            n_w1_v    = 1'b0;
            n_drop    = 1'b0;
            n_btb_sel = fa.btb_valid & (fa.fet_redirect_pc == fa.btb_pc);
            n_btb_ins = fa.btb_instr;
        end else if (accept) begin
            n_pc      = adv_pc;
            n_btb_sel = 1'b0;
            if (take) begin
                n_w0_v = 1'b0;
                n_w1_v = 1'b0;
                n_drop = 1'b0;
            end else if (word_chg) begin
                n_w0   = n_w1;
                n_w0_v = n_w1_v;
                n_w1_v = 1'b0;
                // Old word still owed by the SRAM: its late arrival must not land in W0.
                if (!w0_v_q && !rd_pend_q) begin
                    n_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            pc_q      <= RESET_PC & 32'hFFFF_FFFE;
            w0_q      <= 32'd0;
            w1_q      <= 32'd0;
            w0_v_q    <= 1'b0;
            w1_v_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            btb_sel_q <= 1'b0;
            btb_ins_q <= 32'd0;
            drop_q    <= 1'b0;
            fptr_q    <= RESET_PC[31:2];
        end else begin
            pc_q      <= n_pc;
            w0_q      <= n_w0;
            w1_q      <= n_w1;
            w0_v_q    <= n_w0_v;
            w1_v_q    <= n_w1_v;
            rd_pend_q <= issue;
            btb_sel_q <= n_btb_sel;
            btb_ins_q <= n_btb_ins;
            drop_q    <= n_drop;
            fptr_q    <= n_fptr;
        end
    end

    // JALR (funct3 000) or C.JR/C.JALR (CR format, rs2 = 0, rs1 != 0).
    assign jalr   = ~is16 & (instr[6:0] == 7'b1100111) & (instr[14:12] == 3'b000);
    assign cjr    = is16 & (instr[1:0] == 2'b10) & (instr[15:13] == 3'b100) &
                    (instr[6:2] == 5'd0) & (instr[11:7] != 5'd0);
    assign jr_rs1 = is16 ? instr[11:7] : instr[19:15];

    assign fa.isram_cs         = issue;
    assign fa.isram_addr       = {rd_word, 2'b00};
    assign fa.fet_valid        = valid;
    assign fa.fetch_pc         = pc_q;
    assign fa.rv32_instr_todec = (valid & ~is16) ? instr : 32'd0;
    assign fa.rv16_instr_todec = valid ? instr[15:0] : 16'd0;
    assign fa.fe2de_rv16       = valid & is16;
    assign fa.predict_bxxtaken = take;
    assign fa.cross_bd_ff      = valid & pc_q[1] & ~is16 & ~btb_sel_q;
    assign fa.fet_is_x1        = valid & (jalr | cjr) & (jr_rs1 == 5'd1);
    assign fa.fet_is_xn        = valid & (jalr | cjr) & (jr_rs1 > 5'd1);

endmodule

// File: tb/tb_fetch_align.sv
// Randomized bench for fetch_align: halfword memory image plus an instruction-stream reference model.
module tb_fetch_align;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic cpurst_n;
    always #5 clk = ~clk;

    fetch_align_if bus ();
    fetch_align #(.RESET_PC(RST_PC)) dut (.clk(clk), .cpurst_n(cpurst_n), .fa(bus));

    logic [15:0] mem_h [0:2047];

    always @(posedge clk) begin
        if (bus.isram_cs) begin
            bus.isram_rdata <= {mem_h[{bus.isram_addr[11:2], 1'b1}], mem_h[{bus.isram_addr[11:2], 1'b0}]};
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: where the stream should be and what should be shown next.
    logic [31:0] m_pc;
    bit          m_btb;
    logic [31:0] m_btb_ins;
    bit          m_redir;
    int          m_since, m_lat, m_gap;
    logic        s_cs;

    function automatic logic [15:0] hw(input logic [31:0] a);
        return mem_h[a[11:1]];
    endfunction

    // Cycles from a redirect until the target is presentable from SRAM.
    function automatic int lat_for(input logic [31:0] pc);
        logic [15:0] h;
        h = hw(pc);
        return (pc[1] && h[1:0] == 2'b11) ? 3 : 2;
    endfunction

    // 0: not an indirect jump, 1: through x1, 2: through another register.
    function automatic int jr_kind(input logic [31:0] ins);
        logic [4:0] rs;
        bit hit;
        if (ins[1:0] == 2'b11) begin
            rs  = ins[19:15];
            hit = (ins[6:0] == 7'h67) && (ins[14:12] == 3'd0);
        end else begin
            rs  = ins[11:7];
            hit = (ins[1:0] == 2'b10) && (ins[15:13] == 3'b100) && (ins[6:2] == 5'd0) && (rs != 5'd0);
        end
        if (!hit || rs == 5'd0) return 0;
        return (rs == 5'd1) ? 1 : 2;
    endfunction

    function automatic logic [15:0] gen_half();
        logic [15:0] h;
        int r;
        h = 16'($urandom);
        r = $urandom_range(0, 8);
        case (r)
            0, 1, 2, 3: if (h[1:0] == 2'b11) h[1:0] = 2'b01;
            4, 5:       h[1:0] = 2'b11;
            6:          h[6:0] = 7'b1100011;
            7:          begin h[6:0] = 7'b1100111; h[14:12] = 3'b000; end
            default:    begin h[15:12] = 4'b1000; h[6:0] = 7'b0000010; end
        endcase
        return h;
    endfunction

    function automatic logic [31:0] gen_btb();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0:       return 32'h0000_8067;
            1:       return 32'h0000_8082;
            2:       return v | 32'd3;
            default: return {16'd0, v[15:2], 2'b01};
        endcase
    endfunction

    task automatic redirect_model(input logic [31:0] pc, input bit via_btb, input logic [31:0] bi);
        m_pc      = pc;
        m_btb     = via_btb;
        m_btb_ins = bi;
        m_redir   = 1'b1;
        m_since   = 0;
        m_gap     = 0;
        m_lat     = via_btb ? 1 : lat_for(pc);
    endtask

    // One clock cycle: entered at a falling edge, drives inputs, samples 1ns later.
    task automatic step(input bit st, input bit fl, input logic [31:0] rp,
                        input bit bv, input logic [31:0] bp, input logic [31:0] bi);
        logic [31:0] ins, imm;
        bit v, is16, take;
        int jk;
        bus.fet_stall       = st;
        bus.fet_flush       = fl;
        bus.fet_redirect_pc = rp;
        bus.btb_valid       = bv;
        bus.btb_pc          = bp;
        bus.btb_instr       = bi;
        #1;
        v    = bus.fet_valid;
        s_cs = bus.isram_cs;
        if (bus.isram_cs) chk("addr_align", {30'd0, bus.isram_addr[1:0]}, 32'd0);
        if (m_redir && !fl) begin
            m_since++;
            if (m_since <= m_lat) chk((m_since == m_lat) ? "lat_valid" : "lat_idle", 32'(v), 32'(m_since == m_lat));
            if (m_since >= m_lat) m_redir = 1'b0;
        end
        if (fl) begin
            chk("flush_blocks", 32'(v), 32'd0);
            redirect_model({rp[31:1], 1'b0}, bv && (rp == bp), bi);
        end else if (v) begin
            m_gap = 0;
            ins   = m_btb ? m_btb_ins : {hw(m_pc + 32'd2), hw(m_pc)};
            is16  = (ins[1:0] != 2'b11);
            take  = !is16 && (ins[6:0] == 7'b1100011) && ins[31];
            jk    = jr_kind(ins);
            chk("fetch_pc", bus.fetch_pc, m_pc);
            chk("rv16_flag", 32'(bus.fe2de_rv16), 32'(is16));
            chk("rv16_instr", 32'(bus.rv16_instr_todec), 32'(ins[15:0]));
            chk("rv32_instr", bus.rv32_instr_todec, is16 ? 32'd0 : ins);
            chk("cross_bd", 32'(bus.cross_bd_ff), 32'(!is16 && m_pc[1] && !m_btb));
            chk("predict", 32'(bus.predict_bxxtaken), 32'(take));
            chk("is_x1", 32'(bus.fet_is_x1), 32'(jk == 1));
            chk("is_xn", 32'(bus.fet_is_xn), 32'(jk == 2));
            if (!st) begin
                if (take) begin
                    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                    redirect_model(m_pc + imm, 1'b0, 32'd0);
                end else begin
                    m_pc  = m_pc + (is16 ? 32'd2 : 32'd4);
                    m_btb = 1'b0;
                end
            end
        end else if (!m_redir) begin
            m_gap++;
            chk("stream_gap", 32'(m_gap <= 3), 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic flush_to(input logic [31:0] pc, input bit bv, input logic [31:0] bi);
        step(1'b0, 1'b1, pc, bv, pc, bi);
    endtask

    // Called at a falling edge with reset asserted; releases it and checks the boot read.
    task automatic boot();
        cpurst_n = 1'b1;
        m_pc     = RST_PC & 32'hFFFF_FFFE;
        m_btb    = 1'b0;
        m_redir  = 1'b1;
        m_since  = -1;
        m_lat    = lat_for(m_pc);
        m_gap    = 0;
        bus.fet_stall = 1'b0;
        bus.fet_flush = 1'b0;
        #1;
        chk("boot_cs", 32'(bus.isram_cs), 32'd1);
        chk("boot_addr", bus.isram_addr, RST_PC & 32'hFFFF_FFFC);
    endtask

    task automatic check_reset_state();
        chk("rst_valid", 32'(bus.fet_valid), 32'd0);
        chk("rst_pc", bus.fetch_pc, RST_PC & 32'hFFFF_FFFE);
        chk("rst_cs", 32'(bus.isram_cs), 32'd0);
        chk("rst_rv32", bus.rv32_instr_todec, 32'd0);
        chk("rst_rv16", 32'(bus.rv16_instr_todec), 32'd0);
        chk("rst_flags", {27'd0, bus.fe2de_rv16, bus.predict_bxxtaken, bus.cross_bd_ff,
                          bus.fet_is_x1, bus.fet_is_xn}, 32'd0);
    endtask

    initial begin
        logic [31:0] rp, bp, r;
        bit st, fl, bv;
        for (int i = 0; i < 2048; i++) mem_h[i] = gen_half();
        for (int i = 0; i < 6; i += 2) begin
            mem_h[i]     = 16'h0013;
            mem_h[i + 1] = 16'h0000;
        end
        cpurst_n            = 1'b0;
        bus.fet_stall       = 1'b0;
        bus.fet_flush       = 1'b0;
        bus.fet_redirect_pc = 32'd0;
        bus.btb_valid       = 1'b0;
        bus.btb_pc          = 32'd0;
        bus.btb_instr       = 32'd0;
        repeat (2) @(negedge clk);
        #1 check_reset_state();
        @(negedge clk);

        // Boot stream of NOP words at 0x0/0x4/0x8.
        boot();
        run(8);

        // Compressed then word-crossing 32-bit instruction.
        mem_h[0] = 16'h0001; mem_h[1] = 16'h0013;
        mem_h[2] = 16'h0093; mem_h[3] = 16'h0000;
        flush_to(32'h0, 1'b0, 32'd0);
        run(4);

        // Three stall cycles: prefetch must stop once two words are buffered.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        chk("stall_cs_idle", 32'(s_cs), 32'd0);
        run(4);

        // BTB hit on JALR x0,0(x1); SRAM word at 0x100 differs from the BTB copy.
        mem_h[16'h80] = 16'h0013; mem_h[16'h81] = 16'h0000;
        flush_to(32'h100, 1'b1, 32'h0000_8067);
        run(5);

        // Backward conditional branch at 0x20 predicted taken to 0x18.
        mem_h[16'h10] = 16'h0CE3; mem_h[16'h11] = 16'hFE00;
        flush_to(32'h20, 1'b0, 32'd0);
        run(5);

        // Flush during stall with a read in flight.
        flush_to(32'h4, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 32'd0);
        run(4);

        // PC wrap from the top of the address space.
        mem_h[11'h7FE] = 16'h0001; mem_h[11'h7FF] = 16'h0001;
        flush_to(32'hFFFF_FFFC, 1'b0, 32'd0);
        run(5);

        // Asynchronous reset mid-cycle.
        #2 cpurst_n = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        @(negedge clk);
        boot();
        run(4);

        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 11) == 0);
            r  = $urandom;
            rp = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FF00 | (r & 32'hFF)) : (r & 32'h0000_0FFF);
            bv = ($urandom_range(0, 1) == 1);
            bp = ($urandom_range(0, 1) == 1) ? rp : (rp ^ 32'h4);
            step(st, fl, rp, bv, bp, gen_btb());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
